serial_deframer: RTL and testbench
==================================

Name: serial_deframer

Overview:
- Consumes the registered single-bit serial stream produced by the flip-flop stage, which drives its q onto this block's d.
- Hunts for a fixed sync pattern, then deserializes a fixed number of WIDTH-bit words, MSB first, into a parallel output with a one-cycle valid strobe.
- After the last word of a frame it returns to hunting, so every frame must begin with its own sync pattern.

Parameters:
WIDTH, 8, data word width in bits (2..32)
SYNC_W, 8, sync pattern length in bits (2..32)
SYNC_PAT, 8'hA5, sync pattern, MSB received first; must not be all-zeros
FRAME_WORDS, 2, data words per frame after sync (1..255)

Ports:
clk  input  1  rising-edge clock; d sampled on every rising edge
rst  input  1  synchronous, active-high reset
d  input  1  serial data in, one bit per clock
q  output  WIDTH  last completed word; holds until the next word completes
q_valid  output  1  one-cycle strobe, q updated this cycle
q_idx  output  8  index (0..FRAME_WORDS-1) of the word in q
frame_done  output  1  one-cycle strobe coincident with q_valid of the last word
locked  output  1  1 while in DATA state
par_err  output  1  parity error strobe (see Optional Feature)

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=HUNT; sync shift register, data shift register, bit_cnt and word_cnt cleared.
  - q=0, q_valid=0, q_idx=0, frame_done=0, locked=0, par_err=0.
  - rst has priority over all other events.
- States: HUNT, DATA. Encode them explicitly and default unused codes to HUNT.
- HUNT:
  - Each edge: sync_sr <= {sync_sr[SYNC_W-2:0], d}.
  - The match is tested on the post-shift value {sync_sr[SYNC_W-2:0], d} == SYNC_PAT, so overlapping or partial prefixes are detected with no lost bits.
  - On match, at that same edge: state<=DATA, bit_cnt<=0, word_cnt<=0, locked<=1.
  - The first data bit is the bit sampled on the next edge.
- DATA:
  - Each edge: data_sr <= {data_sr[WIDTH-2:0], d}, bit_cnt++.
  - The sync pattern is not searched for in DATA; data equal to SYNC_PAT is delivered as data.
- Word completion (edge sampling bit WIDTH-1 of a word):
  - q <= {data_sr[WIDTH-2:0], d}, q_valid<=1, q_idx<=word_cnt, bit_cnt<=0, word_cnt++.
  - Latency: q is visible immediately after the edge that samples the word's last bit.
- Frame end (word_cnt==FRAME_WORDS-1 at word completion):
  - frame_done<=1 on the same edge as q_valid; state<=HUNT, locked<=0, sync_sr<=0.
  - Sync hunting restarts with the next sampled bit; bits from the previous frame never contribute to a match.
- q_valid, frame_done and par_err are strobes; they are 0 on every edge that is not a completion edge.
- Reset mid-word or mid-frame: the partial word is discarded, no q_valid is issued, and a new sync is required.
- Counters never wrap inside a frame. bit_cnt is sized clog2(WIDTH+1); word_cnt is 8 bits.

Optional Feature:
- Macro: DEFRAME_PARITY_EN
- Defined:
  - Each data word is followed by one even-parity bit, so each word occupies WIDTH+1 serial bits.
  - Word completion (q, q_valid, q_idx, frame_done) moves to the edge sampling the parity bit; the parity bit is not stored in q.
  - par_err<=1 with q_valid when XOR of the WIDTH data bits and the parity bit is 1; otherwise 0.
  - The frame continues regardless of par_err.
- Undefined: no parity bit is expected; par_err is tied to 0.

Test Plan:
1. rst=1 for 2 edges while d toggles -> after each edge all outputs 0, locked=0; drop rst and hold d=0 for 20 edges -> no lock.
2. Default params; serial 10100101, 00111100, 11110000 ->
   - locked=1 after the 8th edge.
   - After the 16th edge: q=8'h3C, q_valid=1, q_idx=0.
   - After the 24th edge: q=8'hF0, q_idx=1, q_valid=1, frame_done=1, locked=0.
   - After the 25th edge: strobes 0, q holds F0.
3. Prefix 1,1,0,1,0,0,1,0,1 (overlapping partial pattern) followed by data -> locked rises after the 9th edge, and the next 8 bits decode correctly.
4. Sync 10100101 then data 10100101, 01011010 -> q=8'hA5 (idx 0), then 8'h5A (idx 1) with frame_done; no re-sync inside DATA.
5. Sync plus 4 data bits, then rst=1 for 1 edge -> no q_valid, locked=0; resend the full frame -> decodes normally.
6. With DEFRAME_PARITY_EN: sync, 00111100+0, 11110000+1 ->
   - First word: q=3C, par_err=0, q_valid after edge 17.
   - Second word: q=F0, par_err=1, q_valid and frame_done after edge 26.

Source files
------------

// File: rtl/serial_deframer.sv
// Serial deframer: hunts for SYNC_PAT, then unpacks FRAME_WORDS MSB-first words.
// Define DEFRAME_PARITY_EN to expect one even-parity bit after every data word.
//
// state   | meaning
// --------+--------------------------------------------------------------
// HUNT    | shifting d into the sync register, waiting for SYNC_PAT
// DATA    | locked; deserializing words until the frame's last word

module serial_deframer #(
    parameter int                WIDTH       = 8,
    parameter int                SYNC_W      = 8,
    parameter logic [SYNC_W-1:0] SYNC_PAT    = 8'hA5,
    parameter int                FRAME_WORDS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic [7:0]       q_idx,
    output logic             frame_done,
    output logic             locked,
    output logic             par_err
);

`ifdef DEFRAME_PARITY_EN
    localparam int BPW = WIDTH + 1;
`else
    localparam int BPW = WIDTH;
`endif
    // The final bit of a word is used straight from d, so the shift register
    // only needs to hold the bits before it.
    localparam int DSR_W = BPW - 1;
    localparam int BW    = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_HUNT = 2'b01;
    localparam logic [1:0] ST_DATA = 2'b10;

    logic [1:0]        state_q, state_d;
    logic [SYNC_W-2:0] sync_q, sync_d;
    logic [DSR_W-1:0]  data_q, data_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [7:0]        word_q, word_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic              valid_q, valid_d;
    logic [7:0]        idx_q, idx_d;
    logic              done_q, done_d;
    logic              locked_q, locked_d;
    logic              perr_q, perr_d;

    logic [SYNC_W-1:0] sync_shift;
    logic              sync_hit;
    logic              word_end;
    logic              frame_end;

    assign sync_shift = {sync_q, d};
    assign sync_hit   = (state_q == ST_HUNT) && (sync_shift == SYNC_PAT);
    assign word_end   = (state_q == ST_DATA) && (bit_q == BW'(BPW - 1));
    assign frame_end  = word_end && (word_q == 8'(FRAME_WORDS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_HUNT;
            sync_q   <= '0;
            data_q   <= '0;
            bit_q    <= '0;
            word_q   <= '0;
            q_q      <= '0;
            valid_q  <= 1'b0;
            idx_q    <= '0;
            done_q   <= 1'b0;
            locked_q <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            data_q   <= data_d;
            bit_q    <= bit_d;
            word_q   <= word_d;
            q_q      <= q_d;
            valid_q  <= valid_d;
            idx_q    <= idx_d;
            done_q   <= done_d;
            locked_q <= locked_d;
            perr_q   <= perr_d;
        end
    end

    always_comb begin
        state_d = ST_HUNT;
        case (state_q)
            ST_HUNT: state_d = sync_hit ? ST_DATA : ST_HUNT;
            ST_DATA: state_d = frame_end ? ST_HUNT : ST_DATA;
            default: state_d = ST_HUNT;
        endcase
    end

    always_comb begin
        sync_d   = sync_q;
        data_d   = data_q;
        bit_d    = bit_q;
        word_d   = word_q;
        q_d      = q_q;
        valid_d  = 1'b0;
        idx_d    = idx_q;
        done_d   = 1'b0;
        locked_d = locked_q;
        perr_d   = 1'b0;
        case (state_q)
            ST_HUNT: begin
                sync_d = sync_shift[SYNC_W-2:0];
                if (sync_hit) begin
                    bit_d    = '0;
                    word_d   = '0;
                    locked_d = 1'b1;
                end
            end
            ST_DATA: begin
                // Shifting on the parity bit is harmless: the next word's
                // data bits completely refill the register before use.
                data_d = DSR_W'({data_q, d});
                bit_d  = bit_q + BW'(1);
                if (word_end) begin
`ifdef DEFRAME_PARITY_EN
                    q_d    = data_q;
                    perr_d = ^{data_q, d};
`else
                    q_d    = {data_q, d};
`endif
                    valid_d = 1'b1;
                    idx_d   = word_q;
                    bit_d   = '0;
                    word_d  = word_q + 8'd1;
                    if (frame_end) begin
                        done_d   = 1'b1;
                        locked_d = 1'b0;
                        sync_d   = '0;
                    end
                end
            end
            default: ;
        endcase
    end

    assign q          = q_q;
    assign q_valid    = valid_q;
    assign q_idx      = idx_q;
    assign frame_done = done_q;
    assign locked     = locked_q;
`ifdef DEFRAME_PARITY_EN
    assign par_err    = perr_q;
`else
    assign par_err    = 1'b0;
`endif

endmodule

// File: tb/tb_serial_deframer.sv
// Bench for serial_deframer: directed frames plus random streams against a
// bit-level behavioural model of the framing rules.

module tb_serial_deframer;

    localparam int          WIDTH       = 8;
    localparam int          SYNC_W      = 8;
    localparam logic [7:0]  SYNC_PAT    = 8'hA5;
    localparam int          FRAME_WORDS = 2;
`ifdef DEFRAME_PARITY_EN
    localparam int          BPW = WIDTH + 1;
`else
    localparam int          BPW = WIDTH;
`endif
    localparam int          VW  = WIDTH + 12;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             d   = 1'b0;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic [7:0]       q_idx;
    logic             frame_done;
    logic             locked;
    logic             par_err;

    int vectors = 0;
    int errors  = 0;

    serial_deframer #(
        .WIDTH(WIDTH), .SYNC_W(SYNC_W), .SYNC_PAT(SYNC_PAT), .FRAME_WORDS(FRAME_WORDS)
    ) dut (
        .clk(clk), .rst(rst), .d(d), .q(q), .q_valid(q_valid), .q_idx(q_idx),
        .frame_done(frame_done), .locked(locked), .par_err(par_err)
    );

    always #5 clk = ~clk;

    // behavioural model: bit history while hunting, word accumulation while locked
    bit     m_hunt;
    longint m_hist;
    int     m_nbits, m_nwords;
    int     m_word;
    logic [WIDTH-1:0] e_q;
    logic       e_v, e_done, e_lock, e_perr;
    logic [7:0] e_idx;

    function automatic void model_edge(input bit b, input bit r);
        longint mask = (longint'(1) << SYNC_W) - 1;
        if (r) begin
            m_hunt = 1; m_hist = 0; m_nbits = 0; m_nwords = 0; m_word = 0;
            e_q = '0; e_v = 0; e_idx = '0; e_done = 0; e_lock = 0; e_perr = 0;
            return;
        end
        e_v = 0; e_done = 0; e_perr = 0;
        if (m_hunt) begin
            m_hist = ((m_hist << 1) | longint'(b)) & mask;
            if (m_hist == longint'(SYNC_PAT)) begin
                m_hunt = 0; m_nbits = 0; m_nwords = 0; m_word = 0; e_lock = 1;
            end
        end else begin
            m_nbits++;
            if (m_nbits <= WIDTH) m_word = m_word * 2 + int'(b);
            if (m_nbits == BPW) begin
                e_q = WIDTH'(m_word);
                e_v = 1;
                e_idx = 8'(m_nwords);
`ifdef DEFRAME_PARITY_EN
                e_perr = (($countones(WIDTH'(m_word)) + int'(b)) % 2) == 1;
`endif
                m_nwords++; m_nbits = 0; m_word = 0;
                if (m_nwords == FRAME_WORDS) begin
                    e_done = 1; e_lock = 0; m_hunt = 1; m_hist = 0;
                end
            end
        end
    endfunction

    function automatic logic [VW-1:0] obs_v();
        return {q, q_valid, q_idx, frame_done, locked, par_err};
    endfunction

    function automatic logic [VW-1:0] exp_v();
        return {e_q, e_v, e_idx, e_done, e_lock, e_perr};
    endfunction

    task automatic drive(input bit b, input bit r);
        d = b; rst = r;
        @(posedge clk);
        #1;
        model_edge(b, r);
    endtask

    bit stim[$];

    function automatic void push_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) stim.push_back(v[i]);
    endfunction

    function automatic void push_word(input logic [WIDTH-1:0] w, input bit flip);
        push_bits(32'(w), WIDTH);
`ifdef DEFRAME_PARITY_EN
        stim.push_back((^w) ^ flip);
`else
        if (flip) stim.push_back(1'b0);
        if (flip) void'(stim.pop_back());
`endif
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(i[0], 1'b1);
            vectors++;
            if (obs_v() !== {VW{1'b0}} || obs_v() !== exp_v())
                begin errors++; $display("FAIL reset edge %0d: got %h want 0", i, obs_v()); end
        end
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b0);
            vectors++;
            if (locked !== 1'b0 || obs_v() !== exp_v())
                begin errors++; $display("FAIL idle_zero edge %0d: got %h want %h", i, obs_v(), exp_v()); end
        end
    endtask

    task automatic test_frame();
        drive(1'b0, 1'b1);
        stim.delete();
        push_bits(32'(SYNC_PAT), SYNC_W);
        push_word(8'h3C, 1'b0);
        push_word(8'hF0, 1'b0);
        stim.push_back(1'b0);
        for (int i = 0; i < stim.size(); i++) begin
            drive(stim[i], 1'b0);
            vectors++;
            if (obs_v() !== exp_v())
                begin errors++; $display("FAIL frame edge %0d: got %h want %h", i + 1, obs_v(), exp_v()); end
`ifndef DEFRAME_PARITY_EN
            if (i == 7 && locked !== 1'b1)
                begin errors++; $display("FAIL frame_lock: locked=%b want 1", locked); end
            if (i == 15 && {q, q_valid, q_idx} !== {8'h3C, 1'b1, 8'd0})
                begin errors++; $display("FAIL frame_w0: got %h/%b/%0d want 3c/1/0", q, q_valid, q_idx); end
            if (i == 23 && {q, q_valid, q_idx, frame_done, locked} !== {8'hF0, 1'b1, 8'd1, 1'b1, 1'b0})
                begin errors++; $display("FAIL frame_w1: got %h/%b/%0d/%b/%b want f0/1/1/1/0", q, q_valid, q_idx, frame_done, locked); end
            if (i == 24 && {q, q_valid, frame_done} !== {8'hF0, 1'b0, 1'b0})
                begin errors++; $display("FAIL frame_hold: got %h/%b/%b want f0/0/0", q, q_valid, frame_done); end
`endif
        end
    endtask

    task automatic test_overlap();
        drive(1'b0, 1'b1);
        stim.delete();
        push_bits(32'b1_1010_0101, 9);
        push_word(WIDTH'($urandom), 1'b0);
        push_word(WIDTH'($urandom), 1'b0);
        for (int i = 0; i < stim.size(); i++) begin
            drive(stim[i], 1'b0);
            vectors++;
            if (obs_v() !== exp_v())
                begin errors++; $display("FAIL overlap edge %0d: got %h want %h", i + 1, obs_v(), exp_v()); end
            if (i == 7 && locked !== 1'b0)
                begin errors++; $display("FAIL overlap_early: locked=%b want 0", locked); end
            if (i == 8 && locked !== 1'b1)
                begin errors++; $display("FAIL overlap_lock: locked=%b want 1", locked); end
        end
    endtask

    task automatic test_sync_as_data();
        logic [WIDTH-1:0] want[2] = '{8'hA5, 8'h5A};
        int nv = 0;
        drive(1'b0, 1'b1);
        stim.delete();
        push_bits(32'(SYNC_PAT), SYNC_W);
        push_word(8'hA5, 1'b0);
        push_word(8'h5A, 1'b0);
        for (int i = 0; i < stim.size(); i++) begin
            drive(stim[i], 1'b0);
            vectors++;
            if (obs_v() !== exp_v())
                begin errors++; $display("FAIL syncdata edge %0d: got %h want %h", i + 1, obs_v(), exp_v()); end
            if (q_valid === 1'b1) begin
                vectors++;
                if (nv > 1 || q !== want[nv] || q_idx !== 8'(nv) || frame_done !== (nv == 1))
                    begin errors++; $display("FAIL syncdata_word %0d: got %h idx %0d done %b", nv, q, q_idx, frame_done); end
                nv++;
            end
        end
        vectors++;
        if (nv != 2) begin errors++; $display("FAIL syncdata_count: got %0d want 2", nv); end
    endtask

    task automatic test_reset_mid();
        int nv = 0;
        drive(1'b0, 1'b1);
        stim.delete();
        push_bits(32'(SYNC_PAT), SYNC_W);
        push_bits(32'b1011, 4);
        for (int i = 0; i < stim.size(); i++) drive(stim[i], 1'b0);
        drive(1'b1, 1'b1);
        vectors++;
        if (q_valid !== 1'b0 || locked !== 1'b0 || obs_v() !== exp_v())
            begin errors++; $display("FAIL rstmid: got %h want %h", obs_v(), exp_v()); end
        stim.delete();
        push_bits(32'(SYNC_PAT), SYNC_W);
        push_word(8'h3C, 1'b0);
        push_word(8'hF0, 1'b0);
        for (int i = 0; i < stim.size(); i++) begin
            drive(stim[i], 1'b0);
            vectors++;
            if (obs_v() !== exp_v())
                begin errors++; $display("FAIL rstmid_frame edge %0d: got %h want %h", i + 1, obs_v(), exp_v()); end
            if (q_valid === 1'b1) nv++;
        end
        vectors++;
        if (nv != FRAME_WORDS) begin errors++; $display("FAIL rstmid_count: got %0d want %0d", nv, FRAME_WORDS); end
    endtask

`ifdef DEFRAME_PARITY_EN
    task automatic test_parity();
        drive(1'b0, 1'b1);
        stim.delete();
        push_bits(32'(SYNC_PAT), SYNC_W);
        push_bits(32'h3C << 1 | 0, 9);
        push_bits(32'hF0 << 1 | 1, 9);
        for (int i = 0; i < stim.size(); i++) begin
            drive(stim[i], 1'b0);
            vectors++;
            if (obs_v() !== exp_v())
                begin errors++; $display("FAIL parity edge %0d: got %h want %h", i + 1, obs_v(), exp_v()); end
            if (i == 16 && {q, q_valid, par_err, frame_done} !== {8'h3C, 1'b1, 1'b0, 1'b0})
                begin errors++; $display("FAIL parity_w0: got %h/%b/%b want 3c/1/0", q, q_valid, par_err); end
            if (i == 25 && {q, q_valid, par_err, frame_done} !== {8'hF0, 1'b1, 1'b1, 1'b1})
                begin errors++; $display("FAIL parity_w1: got %h/%b/%b/%b want f0/1/1/1", q, q_valid, par_err, frame_done); end
        end
    endtask
`endif

    task automatic test_back_to_back();
        int nd = 0;
        drive(1'b0, 1'b1);
        stim.delete();
        for (int f = 0; f < 5; f++) begin
            push_bits(32'(SYNC_PAT), SYNC_W);
            for (int w = 0; w < FRAME_WORDS; w++) push_word(WIDTH'($urandom), $urandom_range(0, 1) == 1);
        end
        for (int i = 0; i < stim.size(); i++) begin
            drive(stim[i], 1'b0);
            vectors++;
            if (obs_v() !== exp_v())
                begin errors++; $display("FAIL b2b edge %0d: got %h want %h", i + 1, obs_v(), exp_v()); end
            if (frame_done === 1'b1) nd++;
        end
        vectors++;
        if (nd != 5) begin errors++; $display("FAIL b2b_frames: got %0d want 5", nd); end
    endtask

    task automatic test_random();
        drive(1'b0, 1'b1);
        for (int f = 0; f < 60; f++) begin
            stim.delete();
            for (int g = $urandom_range(0, 12); g > 0; g--) stim.push_back($urandom_range(0, 1) == 1);
            push_bits(32'(SYNC_PAT), SYNC_W);
            for (int w = 0; w < FRAME_WORDS; w++) push_word(WIDTH'($urandom), $urandom_range(0, 3) == 0);
            for (int i = 0; i < stim.size(); i++) begin
                drive(stim[i], $urandom_range(0, 150) == 0);
                vectors++;
                if (obs_v() !== exp_v())
                    begin errors++; $display("FAIL random f%0d b%0d: got %h want %h", f, i, obs_v(), exp_v()); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_overlap();
        test_sync_as_data();
        test_reset_mid();
`ifdef DEFRAME_PARITY_EN
        test_parity();
`endif
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
